// File: rtl/operand_fetch_pkg.sv
// Shared types and default sizing for the operand fetch stage and its scoreboard.
package operand_fetch_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NREG       = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2,
    HOLD  = 2'd3
  } of_state_t;

endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set when a writing instruction
// leaves for execute, cleared when its writeback arrives.
module reg_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] q_sr1,
  input  logic [ADDR_W-1:0] q_sr2,
  input  logic [ADDR_W-1:0] q_sr3,
  input  logic [ADDR_W-1:0] q_dr,
  input  logic              q_dr_en,
  output logic              hazard_free
);

  localparam int unsigned N = 2 ** ADDR_W;

  logic [N-1:0] busy;
  logic [N-1:0] set_mask;
  logic [N-1:0] clr_mask;
  logic [N-1:0] busy_eff;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_addr] = 1'b1;
    if (clr_en) clr_mask[clr_addr] = 1'b1;
  end

  // A writeback landing this cycle already frees its register for the query.
  assign busy_eff = busy & ~clr_mask;

  always_comb begin
    hazard_free = ~(busy_eff[q_sr1] | busy_eff[q_sr2] | busy_eff[q_sr3] |
                    (q_dr_en & busy_eff[q_dr]));
  end

  // Set is applied after clear so a same-edge set on the same register wins.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_eff | set_mask;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts decoded instructions when hazard-free, reads the
// register file (one-cycle registered latency) and presents operands to execute.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_sr1,
  input  logic [ADDR_W-1:0] in_sr2,
  input  logic [ADDR_W-1:0] in_sr3,
  input  logic [ADDR_W-1:0] in_dr,
  input  logic              in_wen,
  output logic [ADDR_W-1:0] SR1,
  output logic [ADDR_W-1:0] SR2,
  output logic [ADDR_W-1:0] SR3,
  input  logic [DATA_W-1:0] ReadReg1,
  input  logic [DATA_W-1:0] ReadReg2,
  input  logic [DATA_W-1:0] ReadReg3,
  output logic              RegW,
  output logic [ADDR_W-1:0] DR,
  output logic [DATA_W-1:0] Reg_In,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [DATA_W-1:0] out_op3,
  output logic [ADDR_W-1:0] out_dr,
  output logic              out_wen
);

  of_state_t state;
  of_state_t state_next;

  logic [ADDR_W-1:0] lat_sr1;
  logic [ADDR_W-1:0] lat_sr2;
  logic [ADDR_W-1:0] lat_sr3;
  logic [ADDR_W-1:0] lat_dr;
  logic              lat_wen;
  logic              hazard_free;
  logic              accept;
  logic              fire;

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = DATA;
      DATA:    state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) & ~RST & hazard_free;
    out_valid = (state == HOLD);
  end

  // Read addresses come straight from the latched fields; they only change on
  // accept, so they are valid throughout ISSUE and hold their value elsewhere.
  assign SR1 = lat_sr1;
  assign SR2 = lat_sr2;
  assign SR3 = lat_sr3;

  always_ff @(posedge CLK) begin
    if (RST) begin
      lat_sr1 <= '0;
      lat_sr2 <= '0;
      lat_sr3 <= '0;
      lat_dr  <= '0;
      lat_wen <= 1'b0;
    end else if (accept) begin
      lat_sr1 <= in_sr1;
      lat_sr2 <= in_sr2;
      lat_sr3 <= in_sr3;
      lat_dr  <= in_dr;
      lat_wen <= in_wen;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_op1 <= '0;
      out_op2 <= '0;
      out_op3 <= '0;
      out_dr  <= '0;
      out_wen <= 1'b0;
    end else if (state == DATA) begin
      out_op1 <= ReadReg1;
      out_op2 <= ReadReg2;
      out_op3 <= ReadReg3;
      out_dr  <= lat_dr;
      out_wen <= lat_wen;
    end
  end

  assign RegW   = wb_valid & ~RST;
  assign DR     = wb_dr;
  assign Reg_In = wb_data;

  reg_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk        (CLK),
    .rst        (RST),
    .set_en     (fire & out_wen),
    .set_addr   (out_dr),
    .clr_en     (wb_valid),
    .clr_addr   (wb_dr),
    .q_sr1      (in_sr1),
    .q_sr2      (in_sr2),
    .q_sr3      (in_sr3),
    .q_dr       (in_dr),
    .q_dr_en    (in_wen),
    .hazard_free(hazard_free)
  );

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a register-file environment, a cycle model of the
// stage's observable behaviour, per-cycle comparison and directed scenarios.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid, in_ready;
  logic [AW-1:0] in_sr1, in_sr2, in_sr3, in_dr;
  logic          in_wen;
  logic [AW-1:0] SR1, SR2, SR3;
  logic [DW-1:0] ReadReg1, ReadReg2, ReadReg3;
  logic          RegW;
  logic [AW-1:0] DR;
  logic [DW-1:0] Reg_In;
  logic          wb_valid;
  logic [AW-1:0] wb_dr;
  logic [DW-1:0] wb_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_op1, out_op2, out_op3;
  logic [AW-1:0] out_dr;
  logic          out_wen;

  operand_fetch #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_sr3(in_sr3), .in_dr(in_dr), .in_wen(in_wen),
    .SR1(SR1), .SR2(SR2), .SR3(SR3),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadReg3(ReadReg3),
    .RegW(RegW), .DR(DR), .Reg_In(Reg_In),
    .wb_valid(wb_valid), .wb_dr(wb_dr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_op3(out_op3),
    .out_dr(out_dr), .out_wen(out_wen)
  );

  always #5 CLK = ~CLK;

  // Register file environment: synchronous write, registered read.
  logic [DW-1:0] rf [NREG] = '{default: '0};
  always @(posedge CLK) begin
    if (RegW) rf[DR] <= Reg_In;
    ReadReg1 <= rf[SR1];
    ReadReg2 <= rf[SR2];
    ReadReg3 <= rf[SR3];
  end

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_age counts cycles since accept (-1 when no instruction is held).
  bit            m_busy [NREG];
  logic [DW-1:0] m_rf   [NREG] = '{default: '0};
  int            m_age = -1;
  logic [AW-1:0] m_sr1, m_sr2, m_sr3, m_dr;
  logic          m_wen;
  logic [DW-1:0] m_snap1, m_snap2, m_snap3;
  logic [DW-1:0] m_op1 = '0, m_op2 = '0, m_op3 = '0;
  logic [AW-1:0] m_odr = '0;
  logic          m_owen = 1'b0;

  function automatic bit blocked(input logic [AW-1:0] a);
    return m_busy[a] && !(wb_valid && wb_dr == a);
  endfunction

  function automatic bit model_ready();
    return (m_age < 0) && !RST && !blocked(in_sr1) && !blocked(in_sr2) &&
           !blocked(in_sr3) && !(in_wen && blocked(in_dr));
  endfunction

  task automatic model_step();
    bit acc, fir;
    if (RST) begin
      m_age = -1;
      foreach (m_busy[i]) m_busy[i] = 0;
      m_op1 = '0; m_op2 = '0; m_op3 = '0; m_odr = '0; m_owen = 1'b0;
    end else begin
      acc = in_valid && model_ready();
      fir = (m_age >= 2) && out_ready;
      if (m_age == 1) begin
        m_op1 = m_snap1; m_op2 = m_snap2; m_op3 = m_snap3;
        m_odr = m_dr;    m_owen = m_wen;
      end
      if (m_age == 0) begin
        m_snap1 = m_rf[m_sr1]; m_snap2 = m_rf[m_sr2]; m_snap3 = m_rf[m_sr3];
      end
      if (wb_valid) begin
        m_rf[wb_dr]   = wb_data;
        m_busy[wb_dr] = 0;
      end
      if (fir && m_owen) m_busy[m_odr] = 1;
      if (acc) begin
        m_sr1 = in_sr1; m_sr2 = in_sr2; m_sr3 = in_sr3; m_dr = in_dr; m_wen = in_wen;
      end
      if (fir)                          m_age = -1;
      else if (acc)                     m_age = 0;
      else if (m_age >= 0 && m_age < 2) m_age = m_age + 1;
    end
  endtask

  task automatic compare_all();
    if (!chk_on) return;
    chk("in_ready", in_ready, model_ready());
    chk("out_valid", out_valid, m_age >= 2);
    chk("RegW", RegW, wb_valid && !RST);
    if (wb_valid && !RST) begin
      chk("DR", DR, wb_dr);
      chk("Reg_In", Reg_In, wb_data);
    end
    chk("out_op1", out_op1, m_op1);
    chk("out_op2", out_op2, m_op2);
    chk("out_op3", out_op3, m_op3);
    chk("out_dr", out_dr, m_odr);
    chk("out_wen", out_wen, m_owen);
    if (m_age == 0) begin
      chk("SR1", SR1, m_sr1);
      chk("SR2", SR2, m_sr2);
      chk("SR3", SR3, m_sr3);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic set_in(input logic [AW-1:0] s1, s2, s3, d, input logic w);
    in_sr1 = s1; in_sr2 = s2; in_sr3 = s3; in_dr = d; in_wen = w;
  endtask

  task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1'b1; wb_dr = a; wb_data = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic send(input logic [AW-1:0] s1, s2, s3, d, input logic w);
    bit ok = 0;
    set_in(s1, s2, s3, d, w);
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge CLK);
      if (in_ready) ok = 1;
      tick();
    end
    in_valid = 1'b0;
    chk("accept_timeout", ok, 1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("wait_out_valid", out_valid, 1);
  endtask

  int lat;

  initial begin
    fork
      forever begin @(posedge CLK); model_step(); end
      forever begin @(negedge CLK); compare_all(); end
    join_none

    RST = 1'b1; in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b1;
    wb_dr = '0; wb_data = '0;
    set_in(0, 0, 0, 0, 0);
    tick();
    chk_on = 1;
    tick();
    RST = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_op1", out_op1, 0);

    // Preload and basic fetch
    wb_valid = 1'b1; wb_dr = 5'd1; wb_data = 32'h11;
    #1;
    chk("wb_RegW", RegW, 1);
    chk("wb_DR", DR, 1);
    chk("wb_Reg_In", Reg_In, 32'h11);
    tick();
    wb_valid = 1'b0;
    wb(5'd2, 32'h22);
    wb(5'd3, 32'h33);
    send(1, 2, 3, 0, 0);
    wait_valid(lat);
    chk("basic_latency", lat, 2);
    chk("basic_op1", out_op1, 32'h11);
    chk("basic_op2", out_op2, 32'h22);
    chk("basic_op3", out_op3, 32'h33);
    tick();
    chk("basic_done", out_valid, 0);

    // RAW stall on r5, released by a writeback in the accept cycle
    send(0, 0, 0, 5, 1);
    wait_valid(lat);
    tick();
    set_in(5, 0, 0, 6, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("raw_stall", in_ready, 0);
      tick();
    end
    wb_valid = 1'b1; wb_dr = 5'd5; wb_data = 32'hAB;
    #1 chk("raw_wb_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; wb_valid = 1'b0;
    wait_valid(lat);
    chk("raw_op1", out_op1, 32'hAB);
    chk("raw_out_dr", out_dr, 6);
    chk("raw_out_wen", out_wen, 1);
    tick();
    wb(5'd6, 32'h66);

    // WAW stall on r7; a non-writing instruction to r7 is not stalled
    send(0, 0, 0, 7, 1);
    wait_valid(lat);
    tick();
    set_in(0, 0, 0, 7, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 chk("waw_stall", in_ready, 0);
      tick();
    end
    wb_valid = 1'b1; wb_dr = 5'd7; wb_data = 32'h77;
    #1 chk("waw_wb_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; wb_valid = 1'b0;
    wait_valid(lat);
    tick();
    set_in(0, 0, 0, 7, 0);
    in_valid = 1'b1;
    #1 chk("waw_wen0_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    tick();

    // Backpressure: four held cycles, then a single fire
    out_ready = 1'b0;
    send(1, 2, 3, 8, 0);
    wait_valid(lat);
    set_in(2, 0, 0, 0, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_op1", out_op1, 32'h11);
      chk("bp_op2", out_op2, 32'h22);
      chk("bp_op3", out_op3, 32'h33);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_fire_in_ready", in_ready, 0);
    in_valid = 1'b0;
    tick();
    chk("bp_after_valid", out_valid, 0);
    chk("bp_after_in_ready", in_ready, 1);

    // Same-edge set and clear on r9: set wins
    out_ready = 1'b0;
    send(0, 0, 0, 9, 1);
    wait_valid(lat);
    out_ready = 1'b1;
    wb_valid = 1'b1; wb_dr = 5'd9; wb_data = 32'h99;
    tick();
    wb_valid = 1'b0;
    set_in(9, 0, 0, 0, 0);
    in_valid = 1'b1;
    #1 chk("setclr_busy9", in_ready, 0);
    in_valid = 1'b0;
    tick();

    // Reset while in DATA
    send(1, 2, 3, 10, 1);
    tick();
    RST = 1'b1;
    wb_valid = 1'b1; wb_dr = 5'd4; wb_data = 32'h44;
    #1;
    chk("rstdata_RegW", RegW, 0);
    chk("rstdata_in_ready", in_ready, 0);
    tick();
    RST = 1'b0; wb_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rstdata_no_valid", out_valid, 0);
      tick();
    end
    set_in(9, 7, 4, 7, 1);
    in_valid = 1'b1;
    #1 chk("rstdata_busy_clear", in_ready, 1);
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    chk("rstdata_op1", out_op1, 32'h99);
    chk("rstdata_op2", out_op2, 32'h77);
    chk("rstdata_op3", out_op3, 32'h0);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; the register count is 2**ADDR_W.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the decode-side handshake.
REQ-006 SHALL have ports in_sr1, in_sr2, in_sr3, in_dr (input, ADDR_W each) and in_wen (input, 1): the source, destination and write-enable fields.
REQ-007 SHALL have ports SR1, SR2, SR3 (output, ADDR_W each): register-file read addresses.
REQ-008 SHALL have ports ReadReg1, ReadReg2, ReadReg3 (input, DATA_W each): register-file read data, one-cycle registered latency.
REQ-009 SHALL have ports RegW (output, 1), DR (output, ADDR_W) and Reg_In (output, DATA_W): the register-file write port.
REQ-010 SHALL have ports wb_valid (input, 1), wb_dr (input, ADDR_W) and wb_data (input, DATA_W): writeback request, always accepted.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the execute-side handshake.
REQ-012 SHALL have ports out_op1, out_op2, out_op3 (output, DATA_W each), out_dr (output, ADDR_W) and out_wen (output, 1): the fetched operands and forwarded destination fields.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, DATA and HOLD.
REQ-014 in_ready SHALL be 1 only in IDLE, and only when hazard-free.
REQ-015 An instruction SHALL be hazard-free when none of sr1, sr2, sr3, nor dr (dr checked only if in_wen=1) has its busy bit set, excluding any busy bit cleared by a writeback this same cycle.
REQ-016 On accept (in_valid & in_ready) the block SHALL latch the fields and move IDLE->ISSUE.
REQ-017 In ISSUE, SR1/SR2/SR3 SHALL equal the latched sr1/sr2/sr3, and the next state SHALL be DATA.
REQ-018 In DATA, ReadReg1..3 SHALL be captured into out_op1..3 at the edge, and the state SHALL move to HOLD.
REQ-019 out_valid SHALL be 1 exactly in HOLD, giving 2 cycles of latency from the accept edge to out_valid.
REQ-020 out_op*, out_dr and out_wen SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 On HOLD & out_ready the block SHALL return to IDLE, with no back-to-back accept in that same cycle.
REQ-022 Busy bit[out_dr] SHALL be set at out fire when out_wen=1.
REQ-023 Busy bit[wb_dr] SHALL be cleared at a wb_valid edge.
REQ-024 When a set and a clear target the same address in the same edge, the set SHALL win.
REQ-025 RegW SHALL equal wb_valid & ~RST, with DR=wb_dr and Reg_In=wb_data, combinationally.
REQ-026 A writeback to an address that is not busy SHALL still be written, with no error.
REQ-027 A writeback in the same cycle as an accept reading that address SHALL be visible to the ISSUE read, because the write lands at the accept edge.
REQ-028 Register 0 SHALL be treated as an ordinary register (no hardwired zero).
REQ-029 SR1..3 SHALL hold their last value outside ISSUE.

Reset
REQ-030 While RST=1 at an edge: state SHALL become IDLE, every busy bit 0, out_valid 0, and out_op*, out_dr, out_wen 0.
REQ-031 While RST=1, in_ready SHALL be 0 and RegW SHALL be 0.
REQ-032 Reset mid-operation SHALL drop any in-flight instruction without an out handshake.

Structure
REQ-033 Package operand_fetch_pkg SHALL hold the state enum, the DATA_W/ADDR_W defaults and NREG.
REQ-034 The busy-bit vector with set/clear/query logic SHALL be the sub-module reg_scoreboard.

Verification
REQ-035 Basic fetch: preload r1=0x11, r2=0x22, r3=0x33 via wb; accept sr1=1, sr2=2, sr3=3 -> out_valid 2 cycles later with ops 0x11/0x22/0x33.
REQ-036 RAW stall: issue dr=5 wen=1 and fire out; next instruction has sr1=5 -> in_ready=0 until wb_dr=5, wb_data=0xAB; then accept occurs in the wb cycle and out_op1=0xAB.
REQ-037 WAW stall: pending dr=7; new instruction with dr=7, wen=1 -> stalls until wb_dr=7; a new instruction with dr=7, wen=0 -> accepted immediately.
REQ-038 Backpressure: hold out_ready=0 for 4 cycles -> outputs stable and in_ready=0; releasing it -> one fire, then IDLE.
REQ-039 Same-edge set/clear: out fire with dr=9 while wb_dr=9 in the same cycle -> busy[9]=1 afterwards.
REQ-040 Reset in DATA state: RST=1 for one cycle -> out_valid never rises, all busy bits 0, and RegW=0 during reset.
